// File: rtl/user_spi_flash_reader.sv
// rtl/user_spi_flash_reader.sv - SPI NOR flash word reader (opcode + 24-bit address, 32-bit little-endian read)
//
// Reads one 32-bit word per request from a serial flash in SPI mode 0.
// A transaction shifts READ_CMD and the 24-bit address out MSB first. It then
// clocks in four bytes and returns them assembled little-endian. A short
// chip-select-high gap follows before the next request can be accepted.
//
// Ports:
//   wb_clk_i   - system clock, rising edge
//   wb_rst_i   - synchronous active-high reset
//   req_valid  - read request present
//   req_ready  - block idle and able to accept a request
//   req_addr   - byte address of the word to read
//   rsp_valid  - one-cycle pulse, rsp_data holds the new word
//   rsp_data   - last word read, held until the next rsp_valid
//   busy       - transaction or gap in progress
//   flash_csb  - chip select, active low
//   flash_clk  - SPI clock (idles low)
//   flash_io0  - MOSI
//   flash_io1  - MISO
module user_spi_flash_reader #(
  parameter int          CLK_DIV  = 2,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_next;
  logic [7:0]  div_cnt;
  logic [6:0]  bit_cnt;
  logic        sck;
  logic [31:0] tx_sr;
  logic [30:0] rx_sr;
  logic [31:0] rsp_data_q;
  logic        rsp_valid_q;
  logic [31:0] rx_word;

  logic phase_end;
  logic bit_end;
  logic shifting;
  logic accept;

  assign phase_end = (div_cnt == DIV_LAST);
  // A bit ends on the last system cycle of its high phase.
  assign bit_end   = phase_end && sck;
  assign shifting  = (state == CMD) || (state == ADDR) || (state == DATA);
  assign accept    = req_valid && req_ready;
  // Completed big-endian byte stream including the bit sampled this cycle.
  assign rx_word   = {rx_sr, flash_io1};

  assign req_ready = (state == IDLE) && !wb_rst_i;
  assign busy      = (state != IDLE);
  assign flash_csb = !shifting;
  assign flash_clk = sck;
  assign flash_io0 = ((state == CMD) || (state == ADDR)) && tx_sr[31];
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CMD;
      CMD:  if (bit_end && bit_cnt == 7'd7)  state_next = ADDR;
      ADDR: if (bit_end && bit_cnt == 7'd31) state_next = DATA;
      DATA: if (bit_end && bit_cnt == 7'd63) state_next = GAP;
      // In GAP bit_cnt counts elapsed half-periods; the extra cycle at
      // count 2 gives the 2*CLK_DIV+1 cycle chip-select-high window.
      GAP:  if (bit_cnt == 7'd2) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div_cnt     <= 8'd0;
      bit_cnt     <= 7'd0;
      sck         <= 1'b0;
      tx_sr       <= 32'd0;
      rx_sr       <= 31'd0;
      rsp_data_q  <= 32'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_sr   <= {READ_CMD, req_addr};
            div_cnt <= 8'd0;
            bit_cnt <= 7'd0;
            sck     <= 1'b0;
          end
        end
        CMD, ADDR, DATA: begin
          if (phase_end) begin
            div_cnt <= 8'd0;
            sck     <= ~sck;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
          if (bit_end) begin
            bit_cnt <= bit_cnt + 7'd1;
            // Shifting here makes the next MOSI bit appear at the start of
            // the following low phase.
            tx_sr   <= {tx_sr[30:0], 1'b0};
            if (state == DATA) begin
              rx_sr <= rx_word[30:0];
            end
            if (bit_cnt == 7'd63) begin
              bit_cnt     <= 7'd0;
              // First byte on the wire lands in the least significant lane.
              rsp_data_q  <= {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
              rsp_valid_q <= 1'b1;
            end
          end
        end
        GAP: begin
          if (phase_end) begin
            div_cnt <= 8'd0;
            bit_cnt <= bit_cnt + 7'd1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          div_cnt <= 8'd0;
          bit_cnt <= 7'd0;
          sck     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_spi_flash_reader.sv
// tb/tb_user_spi_flash_reader.sv - directed bench for user_spi_flash_reader with a behavioural SPI flash
module tb_user_spi_flash_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // DUT A: CLK_DIV = 2
  logic        rv_a = 1'b0;
  logic [23:0] ra_a = 24'd0;
  logic        rdy_a, rsp_valid_a, busy_a, csb_a, fclk_a, io0_a, io1_a;
  logic [31:0] rsp_data_a;

  // DUT B: CLK_DIV = 1
  logic        rv_b = 1'b0;
  logic [23:0] ra_b = 24'd0;
  logic        rdy_b, rsp_valid_b, busy_b, csb_b, fclk_b, io0_b, io1_b;
  logic [31:0] rsp_data_b;

  user_spi_flash_reader #(.CLK_DIV(2), .READ_CMD(8'h03)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(rv_a), .req_ready(rdy_a), .req_addr(ra_a),
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .busy(busy_a),
    .flash_csb(csb_a), .flash_clk(fclk_a), .flash_io0(io0_a), .flash_io1(io1_a));

  user_spi_flash_reader #(.CLK_DIV(1), .READ_CMD(8'h03)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(rv_b), .req_ready(rdy_b), .req_addr(ra_b),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b),
    .flash_csb(csb_b), .flash_clk(fclk_b), .flash_io0(io0_b), .flash_io1(io1_b));

  // Flash models: fw holds the four bytes in wire order (first byte in [31:24]).
  logic [31:0] fw_a = 32'd0, fw_b = 32'd0;
  logic [31:0] mosi_a = 32'd0, mosi_b = 32'd0;
  logic [6:0]  nrise_a = 7'd0, nrise_b = 7'd0;

  always @(posedge fclk_a or negedge csb_a) begin
    if (fclk_a) begin
      if (!csb_a) begin
        if (nrise_a < 7'd32) mosi_a <= {mosi_a[30:0], io0_a};
        nrise_a <= nrise_a + 7'd1;
      end
    end else begin
      nrise_a <= 7'd0;
      mosi_a  <= 32'd0;
    end
  end

  always @(posedge fclk_b or negedge csb_b) begin
    if (fclk_b) begin
      if (!csb_b) begin
        if (nrise_b < 7'd32) mosi_b <= {mosi_b[30:0], io0_b};
        nrise_b <= nrise_b + 7'd1;
      end
    end else begin
      nrise_b <= 7'd0;
      mosi_b  <= 32'd0;
    end
  end

  // Current bit index on the wire: rises so far, minus one while SCK is high.
  always @* begin
    int ia;
    ia = fclk_a ? int'(nrise_a) - 1 : int'(nrise_a);
    if (!csb_a && ia >= 32 && ia < 64) io1_a = fw_a[5'(63 - ia)];
    else io1_a = 1'b0;
  end

  always @* begin
    int ib;
    ib = fclk_b ? int'(nrise_b) - 1 : int'(nrise_b);
    if (!csb_b && ib >= 32 && ib < 64) io1_b = fw_b[5'(63 - ib)];
    else io1_b = 1'b0;
  end

  // Monitors sampled mid-cycle.
  int          rsp_cnt_a = 0, rsp_cyc_a = 0, rsp_cnt_b = 0, rsp_cyc_b = 0;
  logic [31:0] rsp_last_a = 32'd0, rsp_last_b = 32'd0;
  logic        csb_at_rsp_a = 1'b0;
  int          acc_q_a[$];
  int          hi_run_a = 0, last_hi_run_a = 0;

  always @(negedge clk) begin
    if (rsp_valid_a) begin
      rsp_cnt_a    = rsp_cnt_a + 1;
      rsp_cyc_a    = cyc;
      rsp_last_a   = rsp_data_a;
      csb_at_rsp_a = csb_a;
    end
    if (rsp_valid_b) begin
      rsp_cnt_b  = rsp_cnt_b + 1;
      rsp_cyc_b  = cyc;
      rsp_last_b = rsp_data_b;
    end
    if (rv_a && rdy_a) acc_q_a.push_back(cyc);
    if (csb_a) hi_run_a = hi_run_a + 1;
    else begin
      if (hi_run_a > 0) last_hi_run_a = hi_run_a;
      hi_run_a = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_a();
    rsp_cnt_a = 0;
    acc_q_a.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_chk++; if (csb_a !== 1'b1) $display("FAIL reset_csb: got %b expected 1", csb_a); else n_pass++;
    n_chk++; if (fclk_a !== 1'b0) $display("FAIL reset_clk: got %b expected 0", fclk_a); else n_pass++;
    n_chk++; if (io0_a !== 1'b0) $display("FAIL reset_io0: got %b expected 0", io0_a); else n_pass++;
    n_chk++; if (rsp_valid_a !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_a); else n_pass++;
    n_chk++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_a); else n_pass++;
    n_chk++; if (rsp_data_a !== 32'd0) $display("FAIL reset_rsp_data: got %h expected 0", rsp_data_a); else n_pass++;
    n_chk++; if (rdy_a !== 1'b0) $display("FAIL reset_ready: got %b expected 0", rdy_a); else n_pass++;
    n_chk++; if (csb_b !== 1'b1) $display("FAIL reset_csb_b: got %b expected 1", csb_b); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (rdy_a !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", rdy_a); else n_pass++;
    step(2);
  endtask

  task automatic test_basic_read();
    int t0;
    clear_a();
    fw_a = 32'h11223344;
    ra_a = 24'h000000; rv_a = 1'b1; t0 = cyc;
    step(1);
    rv_a = 1'b0;
    n_chk++; if (csb_a !== 1'b0) $display("FAIL cmd_csb: got %b expected 0", csb_a); else n_pass++;
    n_chk++; if (fclk_a !== 1'b0) $display("FAIL cmd_clk: got %b expected 0", fclk_a); else n_pass++;
    n_chk++; if (io0_a !== 1'b0) $display("FAIL cmd_io0: got %b expected 0", io0_a); else n_pass++;
    n_chk++; if (busy_a !== 1'b1) $display("FAIL cmd_busy: got %b expected 1", busy_a); else n_pass++;
    step(300);
    n_chk++; if (rsp_cnt_a !== 1) $display("FAIL basic_rsp_count: got %0d expected 1", rsp_cnt_a); else n_pass++;
    n_chk++; if (rsp_cyc_a !== t0 + 257) $display("FAIL basic_rsp_cycle: got %0d expected %0d", rsp_cyc_a, t0 + 257); else n_pass++;
    n_chk++; if (rsp_last_a !== 32'h44332211) $display("FAIL basic_rsp_data: got %h expected 44332211", rsp_last_a); else n_pass++;
    n_chk++; if (csb_at_rsp_a !== 1'b1) $display("FAIL basic_csb_at_r: got %b expected 1", csb_at_rsp_a); else n_pass++;
    n_chk++; if (rsp_data_a !== 32'h44332211) $display("FAIL basic_rsp_hold: got %h expected 44332211", rsp_data_a); else n_pass++;
  endtask

  task automatic test_addr_bits();
    clear_a();
    fw_a = 32'hAABBCCDD;
    ra_a = 24'h123456; rv_a = 1'b1;
    step(1);
    rv_a = 1'b0;
    step(300);
    n_chk++; if (mosi_a !== 32'h03123456) $display("FAIL addr_mosi: got %h expected 03123456", mosi_a); else n_pass++;
    n_chk++; if (nrise_a !== 7'd64) $display("FAIL addr_sck_rises: got %0d expected 64", nrise_a); else n_pass++;
    n_chk++; if (rsp_last_a !== 32'hDDCCBBAA) $display("FAIL addr_rsp_data: got %h expected ddccbbaa", rsp_last_a); else n_pass++;
    n_chk++; if (csb_at_rsp_a !== 1'b1) $display("FAIL addr_csb_at_r: got %b expected 1", csb_at_rsp_a); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t0;
    clear_a();
    fw_a = 32'h55667788;
    ra_a = 24'h000010; rv_a = 1'b1; t0 = cyc;
    step(270);
    rv_a = 1'b0;
    step(280);
    n_chk++; if (acc_q_a.size() !== 2) $display("FAIL b2b_accept_count: got %0d expected 2", acc_q_a.size()); else n_pass++;
    if (acc_q_a.size() >= 2) begin
      n_chk++; if (acc_q_a[1] !== t0 + 262) $display("FAIL b2b_second_accept: got %0d expected %0d", acc_q_a[1], t0 + 262); else n_pass++;
    end
    n_chk++; if (last_hi_run_a < 5) $display("FAIL b2b_csb_gap: got %0d expected >=5", last_hi_run_a); else n_pass++;
    n_chk++; if (rsp_cnt_a !== 2) $display("FAIL b2b_rsp_count: got %0d expected 2", rsp_cnt_a); else n_pass++;
    n_chk++; if (rsp_last_a !== 32'h88776655) $display("FAIL b2b_rsp_data: got %h expected 88776655", rsp_last_a); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_a();
    fw_a = 32'h01020304;
    ra_a = 24'h000000; rv_a = 1'b1;
    step(1);
    rv_a = 1'b0;
    step(180);
    n_chk++; if (csb_a !== 1'b0) $display("FAIL midrst_pre_csb: got %b expected 0", csb_a); else n_pass++;
    rst = 1'b1;
    step(1);
    n_chk++; if (csb_a !== 1'b1) $display("FAIL midrst_csb: got %b expected 1", csb_a); else n_pass++;
    n_chk++; if (fclk_a !== 1'b0) $display("FAIL midrst_clk: got %b expected 0", fclk_a); else n_pass++;
    n_chk++; if (busy_a !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy_a); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (rdy_a !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", rdy_a); else n_pass++;
    step(300);
    n_chk++; if (rsp_cnt_a !== 0) $display("FAIL midrst_no_rsp: got %0d expected 0", rsp_cnt_a); else n_pass++;
    n_chk++; if (rsp_data_a !== 32'd0) $display("FAIL midrst_rsp_data: got %h expected 0", rsp_data_a); else n_pass++;
  endtask

  task automatic test_ignore_during_addr();
    clear_a();
    fw_a = 32'h0F1E2D3C;
    ra_a = 24'hABCDEF; rv_a = 1'b1;
    step(1);
    rv_a = 1'b0;
    step(20);
    for (int i = 0; i < 30; i++) begin
      rv_a = ~rv_a;
      ra_a = 24'($urandom);
      step(1);
    end
    rv_a = 1'b0;
    step(300);
    n_chk++; if (mosi_a !== 32'h03ABCDEF) $display("FAIL ignore_mosi: got %h expected 03abcdef", mosi_a); else n_pass++;
    n_chk++; if (rsp_cnt_a !== 1) $display("FAIL ignore_rsp_count: got %0d expected 1", rsp_cnt_a); else n_pass++;
    n_chk++; if (acc_q_a.size() !== 1) $display("FAIL ignore_accept_count: got %0d expected 1", acc_q_a.size()); else n_pass++;
    n_chk++; if (rsp_last_a !== 32'h3C2D1E0F) $display("FAIL ignore_rsp_data: got %h expected 3c2d1e0f", rsp_last_a); else n_pass++;
  endtask

  task automatic test_clkdiv1();
    int t0;
    rsp_cnt_b = 0;
    fw_b = 32'hEFBEADDE;
    ra_b = 24'h000000; rv_b = 1'b1; t0 = cyc;
    step(1);
    rv_b = 1'b0;
    step(200);
    n_chk++; if (rsp_cnt_b !== 1) $display("FAIL div1_rsp_count: got %0d expected 1", rsp_cnt_b); else n_pass++;
    n_chk++; if (rsp_cyc_b !== t0 + 129) $display("FAIL div1_rsp_cycle: got %0d expected %0d", rsp_cyc_b, t0 + 129); else n_pass++;
    n_chk++; if (rsp_last_b !== 32'hDEADBEEF) $display("FAIL div1_rsp_data: got %h expected deadbeef", rsp_last_b); else n_pass++;
    n_chk++; if (mosi_b !== 32'h03000000) $display("FAIL div1_mosi: got %h expected 03000000", mosi_b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_addr_bits();
    test_back_to_back();
    test_reset_mid();
    test_ignore_during_addr();
    test_clkdiv1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/user_spi_flash_reader.md
USER_SPI_FLASH_READER -- requirements
Module: user_spi_flash_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning system clocks per SCK half-period (legal range 1..255).
REQ-002 SHALL have parameter READ_CMD, default 8'h03, meaning the SPI opcode sent first in every transaction.
REQ-003 SHALL have port wb_clk_i, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1, reset; reset is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, read request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request.
REQ-007 SHALL have port req_addr, input, 24, byte address of the 32-bit word to read.
REQ-008 SHALL have port rsp_valid, output, 1, one-cycle pulse marking rsp_data valid.
REQ-009 SHALL have port rsp_data, output, 32, word read from flash.
REQ-010 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 SHALL have port flash_csb, output, 1, active-low chip select (drives mprj_io[8]).
REQ-012 SHALL have port flash_clk, output, 1, SPI clock (drives mprj_io[9]).
REQ-013 SHALL have port flash_io0, output, 1, MOSI (drives mprj_io[10]).
REQ-014 SHALL have port flash_io1, input, 1, MISO (from mprj_io[11]).

Function
REQ-015 SHALL implement states IDLE, CMD (8 bits), ADDR (24 bits), DATA (32 bits), GAP.
REQ-016 SHALL drive req_ready = (state==IDLE) && !wb_rst_i; a request is accepted on a cycle T0 with req_valid && req_ready, capturing req_addr.
REQ-017 SHALL, at T0+1, enter CMD with flash_csb=0, flash_clk=0, and flash_io0 = READ_CMD[7].
REQ-018 SHALL use SPI mode 0: each bit is CLK_DIV cycles with flash_clk=0, then CLK_DIV cycles with flash_clk=1; flash_io0 changes only at the start of a low phase.
REQ-019 SHALL shift READ_CMD then req_addr[23:0] out MSB first, 32 bits total; flash_io0 SHALL be 0 during DATA.
REQ-020 SHALL sample flash_io1 on the last system cycle of each DATA high phase, MSB first within each byte.
REQ-021 SHALL assemble little-endian: the first byte received goes to rsp_data[7:0], the fourth to rsp_data[31:24].
REQ-022 SHALL, at R = T0+1+128*CLK_DIV, drive flash_csb=1, flash_clk=0, and pulse rsp_valid for exactly one cycle with rsp_data valid.
REQ-023 SHALL hold rsp_data stable from R until the next rsp_valid.
REQ-024 SHALL stay in GAP for cycles R..R+2*CLK_DIV with flash_csb=1 and enter IDLE at R+2*CLK_DIV+1.
REQ-025 SHALL ignore req_valid and req_addr changes outside IDLE; there is no request buffering.
REQ-026 SHALL use an internal bit counter of 7 bits and a divider counter of 8 bits, both wrap-free (reloaded per bit and per transaction).

Reset
REQ-027 SHALL, on any cycle with wb_rst_i=1 (including mid-transaction), set state IDLE, flash_csb=1, flash_clk=0, flash_io0=0, rsp_valid=0, busy=0, rsp_data=0, req_ready=0.
REQ-028 SHALL abort any in-flight transaction on reset without issuing rsp_valid.
REQ-029 SHALL assert req_ready on the first cycle after wb_rst_i deasserts.

Verification
REQ-030 SHALL verify: flash bytes 11 22 33 44 at 0x000000, request addr 0x000000 at T0 with CLK_DIV=2 -> rsp_valid only at T0+257, rsp_data=0x44332211.
REQ-031 SHALL verify: request addr 0x123456 -> bits sampled on flash_clk rising edges are 0x03,0x12,0x34,0x56, then flash_csb=1 at R.
REQ-032 SHALL verify: req_valid held high across two requests -> second acceptance at R+2*CLK_DIV+1 and flash_csb high for at least 2*CLK_DIV+1 cycles between transactions.
REQ-033 SHALL verify: wb_rst_i pulsed for 1 cycle during DATA -> next cycle flash_csb=1, flash_clk=0, no rsp_valid, and req_ready=1 after release.
REQ-034 SHALL verify: CLK_DIV=1, flash word 0xDEADBEEF (bytes EF BE AD DE) -> rsp_valid at T0+129, rsp_data=0xDEADBEEF.
REQ-035 SHALL verify: req_valid toggled and req_addr changed during ADDR -> transmitted address unchanged, single rsp_valid.
